operand_seq: RTL and testbench

//  Operand-fetch sequencer sitting directly upstream of the pipeline datapath. It drives that

---
 rtl/operand_seq.sv | 211 +++++++++++++++++++++
 tb/tb_operand_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_seq.sv
// Operand-fetch sequencer for an MSP430-style datapath.
// Walks the addressing modes of one decoded instruction: source extension-word fetch,
// source memory read, destination extension-word fetch, destination memory read.
// It then presents the resolved operands to execute with a valid/ready handshake.
// All outputs are registered. Each output is loaded on the transition into the state
// that uses it, so MAB_SEL is already correct during that state's memory read.
module operand_seq #(
    parameter int          SIZE     = 16,
    parameter logic [2:0]  MAB_PC   = 3'd0,
    parameter logic [2:0]  MAB_CALC = 3'd1,
    parameter logic [2:0]  MAB_SRC  = 3'd2,
    parameter logic [2:0]  MAB_DST  = 3'd3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [1:0]       FORMAT,
    input  logic [2:0]       AdAs,
    input  logic             BW,
    input  logic [3:0]       reg_SA,
    input  logic [3:0]       reg_DA,
    input  logic [SIZE-1:0]  Sout,
    input  logic [SIZE-1:0]  Dout,
    input  logic [SIZE-1:0]  MDB_out,
    input  logic             exec_ready,
    output logic [2:0]       MAB_SEL,
    output logic [SIZE-1:0]  CALC_OUT,
    output logic             pc_inc,
    output logic             sa_inc,
    output logic [1:0]       sa_step,
    output logic [SIZE-1:0]  src_op,
    output logic [SIZE-1:0]  dst_op,
    output logic [SIZE-1:0]  dst_addr,
    output logic             op_valid,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_SX_FETCH, S_SRC_RD, S_DX_FETCH, S_DST_RD, S_EXEC
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        fmt_q, fmt_d, as_q, as_d;
    logic              ad_q, ad_d;
    logic [3:0]        sa_q, sa_d, da_q, da_d;
    logic [2:0]        mab_sel_q, mab_sel_d;
    logic [SIZE-1:0]   calc_q, calc_d, src_op_q, src_op_d, dst_op_q, dst_op_d;
    logic [SIZE-1:0]   dst_addr_q, dst_addr_d;
    logic              pc_inc_q, pc_inc_d, sa_inc_q, sa_inc_d, op_valid_q, op_valid_d;
    logic              busy_q, busy_d;
    logic [1:0]        sa_step_q, sa_step_d;

    // Working view of the instruction fields: live inputs while idle, latched copy otherwise.
    logic [1:0]        f_fmt, f_as;
    logic              f_ad;
    logic [3:0]        f_sa;
    logic              is_const, src_mem, src_x, dst_x, autoinc;

    // MAB_DST belongs to the shared select encoding but this sequencer never issues it.
    logic              unused_mab_dst;
    assign unused_mab_dst = ^MAB_DST;

    // R3 (any As) and R2 (As=10/11) act as constant generators.
    function automatic logic [SIZE-1:0] const_gen(input logic [3:0] sa, input logic [1:0] as);
        logic [SIZE-1:0] v;
        if (sa == 4'd2) begin
            v = as[0] ? SIZE'(8) : SIZE'(4);
        end else begin
            case (as)
                2'b00:   v = '0;
                2'b01:   v = SIZE'(1);
                2'b10:   v = SIZE'(2);
                default: v = '1;
            endcase
        end
        return v;
    endfunction

    // Decode which addressing phases the current instruction needs.
    always_comb begin
        f_fmt    = (state_q == S_IDLE) ? FORMAT    : fmt_q;
        f_as     = (state_q == S_IDLE) ? AdAs[1:0] : as_q;
        f_ad     = (state_q == S_IDLE) ? AdAs[2]   : ad_q;
        f_sa     = (state_q == S_IDLE) ? reg_SA    : sa_q;
        is_const = (f_sa == 4'd3) || ((f_sa == 4'd2) && f_as[1]);
        src_mem  = !f_fmt[1] && !is_const && (f_as != 2'b00);
        src_x    = src_mem && (f_as == 2'b01);
        autoinc  = src_mem && (f_as == 2'b11);
        dst_x    = (f_fmt == 2'b00) && f_ad;
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d    = state_q;
        fmt_d      = fmt_q;
        as_d       = as_q;
        ad_d       = ad_q;
        sa_d       = sa_q;
        da_d       = da_q;
        calc_d     = calc_q;
        src_op_d   = src_op_q;
        dst_op_d   = dst_op_q;
        dst_addr_d = dst_addr_q;
        sa_step_d  = sa_step_q;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    fmt_d      = FORMAT;
                    as_d       = AdAs[1:0];
                    ad_d       = AdAs[2];
                    sa_d       = reg_SA;
                    da_d       = reg_DA;
                    // Byte autoincrement steps by 1 except on PC and SP, which stay word aligned.
                    sa_step_d  = (BW && (reg_SA > 4'd1)) ? 2'd1 : 2'd2;
                    dst_addr_d = '0;
                    src_op_d   = f_fmt[1] ? '0 : (is_const ? const_gen(f_sa, f_as) : Sout);
                    dst_op_d   = (f_fmt == 2'b00 && !f_ad) ? Dout : '0;
                    if (src_x)        state_d = S_SX_FETCH;
                    else if (src_mem) state_d = S_SRC_RD;
                    else if (dst_x)   state_d = S_DX_FETCH;
                    else              state_d = S_EXEC;
                end
            end
            S_SX_FETCH: begin
                calc_d  = (sa_q == 4'd2) ? MDB_out : Sout + MDB_out;
                state_d = S_SRC_RD;
            end
            S_SRC_RD: begin
                src_op_d = MDB_out;
                state_d  = dst_x ? S_DX_FETCH : S_EXEC;
            end
            S_DX_FETCH: begin
                calc_d     = (da_q == 4'd2) ? MDB_out : Dout + MDB_out;
                dst_addr_d = calc_d;
                state_d    = S_DST_RD;
            end
            S_DST_RD: begin
                dst_op_d = MDB_out;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                if (exec_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs that belong to the state being entered.
        case (state_d)
            S_SRC_RD: mab_sel_d = (state_q == S_SX_FETCH) ? MAB_CALC : MAB_SRC;
            S_DST_RD: mab_sel_d = MAB_CALC;
            default:  mab_sel_d = MAB_PC;
        endcase
        pc_inc_d   = (state_d == S_SX_FETCH) || (state_d == S_DX_FETCH) ||
                     ((state_d == S_SRC_RD) && autoinc && (f_sa == 4'd0));
        sa_inc_d   = (state_d == S_SRC_RD) && autoinc && (f_sa != 4'd0);
        op_valid_d = (state_d == S_EXEC);
        busy_d     = (state_d != S_IDLE);
    end

    // Sequencer state and registered outputs; reset clears any pending pulse at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fmt_q      <= '0;
            as_q       <= '0;
            ad_q       <= 1'b0;
            sa_q       <= '0;
            da_q       <= '0;
            mab_sel_q  <= MAB_PC;
            calc_q     <= '0;
            src_op_q   <= '0;
            dst_op_q   <= '0;
            dst_addr_q <= '0;
            pc_inc_q   <= 1'b0;
            sa_inc_q   <= 1'b0;
            sa_step_q  <= 2'd2;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fmt_q      <= fmt_d;
            as_q       <= as_d;
            ad_q       <= ad_d;
            sa_q       <= sa_d;
            da_q       <= da_d;
            mab_sel_q  <= mab_sel_d;
            calc_q     <= calc_d;
            src_op_q   <= src_op_d;
            dst_op_q   <= dst_op_d;
            dst_addr_q <= dst_addr_d;
            pc_inc_q   <= pc_inc_d;
            sa_inc_q   <= sa_inc_d;
            sa_step_q  <= sa_step_d;
            op_valid_q <= op_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign MAB_SEL  = mab_sel_q;
    assign CALC_OUT = calc_q;
    assign pc_inc   = pc_inc_q;
    assign sa_inc   = sa_inc_q;
    assign sa_step  = sa_step_q;
    assign src_op   = src_op_q;
    assign dst_op   = dst_op_q;
    assign dst_addr = dst_addr_q;
    assign op_valid = op_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_operand_seq.sv
// Directed bench for operand_seq with a small memory model behind the address mux.
module tb_operand_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, BW, exec_ready;
    logic [1:0]  FORMAT;
    logic [2:0]  AdAs;
    logic [3:0]  reg_SA, reg_DA;
    logic [15:0] Sout, Dout, MDB_out;
    logic [2:0]  MAB_SEL;
    logic [15:0] CALC_OUT, src_op, dst_op, dst_addr;
    logic        pc_inc, sa_inc, op_valid, busy;
    logic [1:0]  sa_step;

    int n_checks = 0;
    int n_errors = 0;
    int pc_cnt = 0;
    int sa_cnt = 0;

    logic [15:0] maddr [4];
    logic [15:0] mdat  [4];
    logic        mval  [4];
    logic [15:0] pc_now, mab;

    operand_seq dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .FORMAT(FORMAT), .AdAs(AdAs),
        .BW(BW), .reg_SA(reg_SA), .reg_DA(reg_DA), .Sout(Sout), .Dout(Dout),
        .MDB_out(MDB_out), .exec_ready(exec_ready), .MAB_SEL(MAB_SEL), .CALC_OUT(CALC_OUT),
        .pc_inc(pc_inc), .sa_inc(sa_inc), .sa_step(sa_step), .src_op(src_op),
        .dst_op(dst_op), .dst_addr(dst_addr), .op_valid(op_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Program counter model: starts at 1000 and advances by 2 per pc_inc pulse.
    always @(posedge clk) begin
        if (pc_inc) pc_cnt <= pc_cnt + 1;
        if (sa_inc) sa_cnt <= sa_cnt + 1;
    end
    assign pc_now = 16'h1000 + 16'(pc_cnt * 2);

    // Memory: address from the select code, data from the small table (DEAD if unmapped).
    always_comb begin
        case (MAB_SEL)
            3'd0:    mab = pc_now;
            3'd1:    mab = CALC_OUT;
            3'd2:    mab = Sout;
            default: mab = Dout;
        endcase
        MDB_out = 16'hDEAD;
        for (int i = 0; i < 4; i++)
            if (mval[i] && maddr[i] == mab) MDB_out = mdat[i];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic mem_clear();
        for (int i = 0; i < 4; i++) mval[i] = 1'b0;
    endtask

    task automatic mem_set(input int idx, input logic [15:0] a, input logic [15:0] d);
        maddr[idx] = a;
        mdat[idx]  = d;
        mval[idx]  = 1'b1;
    endtask

    // Present an instruction for one cycle; returns at the negedge of cycle 1.
    task automatic start(input logic [1:0] fmt, input logic [2:0] adas, input logic bw,
                         input logic [3:0] sa, input logic [3:0] da);
        FORMAT = fmt; AdAs = adas; BW = bw; reg_SA = sa; reg_DA = da;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic wait_op(output int cyc);
        cyc = 1;
        while (!op_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic finish_xfer(input string tag);
        @(negedge clk);
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    int cyc, pc0, sa0;

    initial begin
        rst = 1'b1; instr_valid = 1'b0; BW = 1'b0; exec_ready = 1'b1;
        FORMAT = 2'b00; AdAs = 3'b000; reg_SA = 4'd0; reg_DA = 4'd0;
        Sout = 16'h0; Dout = 16'h0;
        mem_clear();
        @(negedge clk); @(negedge clk);
        check("rst_mab",     {29'd0, MAB_SEL}, 32'd0);
        check("rst_busy",    {31'd0, busy}, 32'd0);
        check("rst_valid",   {31'd0, op_valid}, 32'd0);
        check("rst_sa_step", {30'd0, sa_step}, 32'd2);
        check("rst_src",     {16'd0, src_op}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // MOV R5,R6
        Sout = 16'h1234; Dout = 16'h0000; pc0 = pc_cnt;
        start(2'b00, 3'b000, 1'b0, 4'd5, 4'd6);
        wait_op(cyc);
        check("mov_cycle", cyc, 1);
        check("mov_src", {16'd0, src_op}, 32'h1234);
        check("mov_dst", {16'd0, dst_op}, 32'h0000);
        check("mov_pcinc", pc_cnt - pc0, 0);
        finish_xfer("mov_idle");

        // ADD 4(R5),R6
        mem_clear();
        mem_set(0, pc_now, 16'h0004);
        mem_set(1, 16'h0104, 16'hBEEF);
        Sout = 16'h0100; Dout = 16'h5555; pc0 = pc_cnt; sa0 = sa_cnt;
        start(2'b00, 3'b001, 1'b0, 4'd5, 4'd6);
        check("add_pcinc_sx", {31'd0, pc_inc}, 32'd1);
        wait_op(cyc);
        check("add_cycle", cyc, 3);
        check("add_calc", {16'd0, CALC_OUT}, 32'h0104);
        check("add_src", {16'd0, src_op}, 32'hBEEF);
        check("add_dst", {16'd0, dst_op}, 32'h5555);
        check("add_pcinc", pc_cnt - pc0, 1);
        check("add_sainc", sa_cnt - sa0, 0);
        finish_xfer("add_idle");

        // MOV.B @R7+,&0200
        mem_clear();
        mem_set(0, 16'h0300, 16'h00AB);
        mem_set(1, pc_now, 16'h0200);
        mem_set(2, 16'h0200, 16'h1111);
        Sout = 16'h0300; Dout = 16'h7000; pc0 = pc_cnt; sa0 = sa_cnt;
        start(2'b00, 3'b111, 1'b1, 4'd7, 4'd2);
        check("movb_sainc_pulse", {31'd0, sa_inc}, 32'd1);
        check("movb_step", {30'd0, sa_step}, 32'd1);
        wait_op(cyc);
        check("movb_cycle", cyc, 4);
        check("movb_src", {16'd0, src_op}, 32'h00AB);
        check("movb_dst_addr", {16'd0, dst_addr}, 32'h0200);
        check("movb_dst", {16'd0, dst_op}, 32'h1111);
        check("movb_pcinc", pc_cnt - pc0, 1);
        check("movb_sainc", sa_cnt - sa0, 1);
        finish_xfer("movb_idle");

        // Constant generator R3, As=11 -> FFFF with no memory access
        mem_clear();
        Sout = 16'h4321; pc0 = pc_cnt; sa0 = sa_cnt;
        start(2'b01, 3'b011, 1'b0, 4'd3, 4'd0);
        check("cg3_mab", {29'd0, MAB_SEL}, 32'd0);
        wait_op(cyc);
        check("cg3_cycle", cyc, 1);
        check("cg3_src", {16'd0, src_op}, 32'hFFFF);
        check("cg3_dst", {16'd0, dst_op}, 32'h0000);
        check("cg3_pcinc", pc_cnt - pc0, 0);
        check("cg3_sainc", sa_cnt - sa0, 0);
        finish_xfer("cg3_idle");

        // Constant generator R2, As=10 -> 4
        start(2'b01, 3'b010, 1'b0, 4'd2, 4'd0);
        wait_op(cyc);
        check("cg2_src", {16'd0, src_op}, 32'h0004);
        finish_xfer("cg2_idle");

        // Immediate @PC+: PC advances, no sa_inc, word step
        mem_clear();
        mem_set(0, pc_now, 16'h7777);
        Sout = pc_now; pc0 = pc_cnt; sa0 = sa_cnt;
        start(2'b01, 3'b011, 1'b1, 4'd0, 4'd0);
        check("imm_step", {30'd0, sa_step}, 32'd2);
        wait_op(cyc);
        check("imm_cycle", cyc, 2);
        check("imm_src", {16'd0, src_op}, 32'h7777);
        check("imm_pcinc", pc_cnt - pc0, 1);
        check("imm_sainc", sa_cnt - sa0, 0);
        finish_xfer("imm_idle");

        // Indexed address wraps: FFFE + 0004 = 0002
        mem_clear();
        mem_set(0, pc_now, 16'h0004);
        mem_set(1, 16'h0002, 16'hCAFE);
        Sout = 16'hFFFE;
        start(2'b01, 3'b001, 1'b0, 4'd4, 4'd0);
        wait_op(cyc);
        check("wrap_calc", {16'd0, CALC_OUT}, 32'h0002);
        check("wrap_src", {16'd0, src_op}, 32'hCAFE);
        finish_xfer("wrap_idle");

        // Jump format: operands cleared
        Sout = 16'h1234; Dout = 16'h9999;
        start(2'b10, 3'b000, 1'b0, 4'd5, 4'd6);
        wait_op(cyc);
        check("jmp_cycle", cyc, 1);
        check("jmp_src", {16'd0, src_op}, 32'h0000);
        check("jmp_dst", {16'd0, dst_op}, 32'h0000);
        finish_xfer("jmp_idle");

        // Back-pressure: outputs hold, new instruction ignored
        exec_ready = 1'b0;
        Sout = 16'hAAAA; Dout = 16'hBBBB;
        start(2'b00, 3'b000, 1'b0, 4'd5, 4'd6);
        for (int i = 0; i < 3; i++) begin
            FORMAT = 2'b01; AdAs = 3'b011; reg_SA = 4'd3; Sout = 16'h5555;
            instr_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", {31'd0, op_valid}, 32'd1);
            check("hold_src", {16'd0, src_op}, 32'hAAAA);
            check("hold_dst", {16'd0, dst_op}, 32'hBBBB);
        end
        instr_valid = 1'b0;
        exec_ready = 1'b1;
        finish_xfer("hold_idle");
        @(negedge clk);
        check("hold_no_pending", {31'd0, busy}, 32'd0);

        // Asynchronous reset while in DX_FETCH
        mem_clear();
        Dout = 16'h0100;
        start(2'b00, 3'b100, 1'b0, 4'd5, 4'd6);
        check("dx_pcinc", {31'd0, pc_inc}, 32'd1);
        pc0 = pc_cnt;
        #2 rst = 1'b1;
        #1;
        check("arst_pcinc", {31'd0, pc_inc}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_mab", {29'd0, MAB_SEL}, 32'd0);
        check("arst_calc", {16'd0, CALC_OUT}, 32'd0);
        check("arst_src", {16'd0, src_op}, 32'd0);
        check("arst_dst", {16'd0, dst_op}, 32'd0);
        check("arst_dst_addr", {16'd0, dst_addr}, 32'd0);
        check("arst_step", {30'd0, sa_step}, 32'd2);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_no_pulse", pc_cnt - pc0, 0);
        check("arst_idle", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
